// File: rtl/pkt_buffer_ram.sv
// Packet store-and-forward buffer: packets are written speculatively into a circular RAM,
// committed through a descriptor FIFO on eop, and streamed out word by word with backpressure.
module pkt_buffer_ram #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int PCK_LEN    = 12,
    parameter int DESC_AW    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  enq_in_sop,
    input  logic                  enq_in_eop,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  deq_valid,
    output logic                  enq_out_sop,
    output logic                  enq_out_eop,
    output logic [PCK_LEN-1:0]    pkt_len_out,
    output logic [DESC_AW:0]      pkt_count,
    output logic [ADDR_WIDTH:0]   free_words,
    output logic                  drop
);

    localparam int DEPTH      = 2**ADDR_WIDTH;
    localparam int DESC_DEPTH = 2**DESC_AW;
    localparam logic [PCK_LEN-1:0] MAX_LEN = '1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_PKT  = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;

    localparam logic R_IDLE   = 1'b0;
    localparam logic R_STREAM = 1'b1;

    logic [DATA_WIDTH-1:0] mem        [DEPTH];
    logic [ADDR_WIDTH-1:0] desc_start [DESC_DEPTH];
    logic [PCK_LEN-1:0]    desc_len   [DESC_DEPTH];

    logic [DESC_AW:0]      desc_wr_ptr;
    logic [DESC_AW:0]      desc_rd_ptr;
    logic [DESC_AW:0]      desc_count;

    logic [1:0]            w_state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] pkt_start;
    logic [PCK_LEN-1:0]    wr_len;

    logic                  r_state;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [PCK_LEN-1:0]    rd_left;

    logic                  start_new;
    logic                  abort;
    logic                  accept;
    logic                  full_ram;
    logic                  full_desc;
    logic                  too_long;
    logic                  drop_now;
    logic                  store;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] base_ptr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] commit_start;
    logic [PCK_LEN-1:0]    cur_len;
    logic [PCK_LEN-1:0]    rewind_len;

    logic                  out_free;
    logic                  consume;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] head_start;
    logic [PCK_LEN-1:0]    head_len;

    // A sop inside an open packet aborts it; the fresh packet reuses the abandoned start address.
    assign start_new    = wr_en && enq_in_sop && (w_state != W_DROP);
    assign abort        = wr_en && enq_in_sop && (w_state == W_PKT);
    assign accept       = start_new || (wr_en && (w_state == W_PKT));
    assign base_ptr     = (w_state == W_PKT) ? pkt_start : wr_ptr;
    assign wr_addr      = start_new ? base_ptr : wr_ptr;
    assign cur_len      = start_new ? '0 : wr_len;
    assign commit_start = start_new ? base_ptr : pkt_start;

    // An abort releases the open packet's words, so the RAM cannot be full for the new sop word.
    assign full_ram   = (free_words == '0) && !abort;
    assign full_desc  = start_new && (desc_count == (DESC_AW+1)'(DESC_DEPTH));
    assign too_long   = (cur_len == MAX_LEN);
    assign drop_now   = accept && (full_ram || full_desc || too_long);
    assign store      = accept && !drop_now;
    assign commit     = store && enq_in_eop;
    assign rewind_len = (abort || (drop_now && (w_state == W_PKT))) ? wr_len : '0;

    assign desc_count = desc_wr_ptr - desc_rd_ptr;
    assign head_start = desc_start[desc_rd_ptr[DESC_AW-1:0]];
    assign head_len   = desc_len[desc_rd_ptr[DESC_AW-1:0]];
    assign out_free   = !deq_valid || rd_en;
    assign consume    = deq_valid && rd_en;
    assign pop        = (r_state == R_IDLE) && (desc_count != '0) && out_free;

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_addr] <= data_in;
        end
        if (commit) begin
            desc_start[desc_wr_ptr[DESC_AW-1:0]] <= commit_start;
            desc_len[desc_wr_ptr[DESC_AW-1:0]]   <= cur_len + PCK_LEN'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state     <= W_IDLE;
            wr_ptr      <= '0;
            pkt_start   <= '0;
            wr_len      <= '0;
            desc_wr_ptr <= '0;
            desc_rd_ptr <= '0;
            drop        <= 1'b0;
            pkt_count   <= '0;
            free_words  <= (ADDR_WIDTH+1)'(DEPTH);
        end else begin
            drop <= drop_now || abort;
            if (accept) begin
                if (drop_now) begin
                    wr_ptr  <= base_ptr;
                    wr_len  <= '0;
                    w_state <= enq_in_eop ? W_IDLE : W_DROP;
                end else begin
                    wr_ptr <= wr_addr + ADDR_WIDTH'(1);
                    if (start_new) begin
                        pkt_start <= base_ptr;
                    end
                    if (enq_in_eop) begin
                        wr_len  <= '0;
                        w_state <= W_IDLE;
                    end else begin
                        wr_len  <= cur_len + PCK_LEN'(1);
                        w_state <= W_PKT;
                    end
                end
            end else if (wr_en && enq_in_eop && (w_state == W_DROP)) begin
                w_state <= W_IDLE;
            end
            if (commit) begin
                desc_wr_ptr <= desc_wr_ptr + (DESC_AW+1)'(1);
            end
            if (pop) begin
                desc_rd_ptr <= desc_rd_ptr + (DESC_AW+1)'(1);
            end
            free_words <= free_words + (ADDR_WIDTH+1)'(consume) + (ADDR_WIDTH+1)'(rewind_len)
                          - (ADDR_WIDTH+1)'(store);
            pkt_count  <= pkt_count + (DESC_AW+1)'(commit) - (DESC_AW+1)'(consume && enq_out_eop);
        end
    end

    // The output register doubles as the RAM read register; a pop fetches the packet's first word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= R_IDLE;
            rd_ptr      <= '0;
            rd_left     <= '0;
            data_out    <= '0;
            deq_valid   <= 1'b0;
            enq_out_sop <= 1'b0;
            enq_out_eop <= 1'b0;
            pkt_len_out <= '0;
        end else begin
            if (pop) begin
                data_out    <= mem[head_start];
                rd_ptr      <= head_start + ADDR_WIDTH'(1);
                rd_left     <= head_len - PCK_LEN'(1);
                pkt_len_out <= head_len;
                deq_valid   <= 1'b1;
                enq_out_sop <= 1'b1;
                enq_out_eop <= (head_len == PCK_LEN'(1));
                r_state     <= (head_len == PCK_LEN'(1)) ? R_IDLE : R_STREAM;
            end else if ((r_state == R_STREAM) && out_free) begin
                data_out    <= mem[rd_ptr];
                rd_ptr      <= rd_ptr + ADDR_WIDTH'(1);
                rd_left     <= rd_left - PCK_LEN'(1);
                deq_valid   <= 1'b1;
                enq_out_sop <= 1'b0;
                enq_out_eop <= (rd_left == PCK_LEN'(1));
                if (rd_left == PCK_LEN'(1)) begin
                    r_state <= R_IDLE;
                end
            end else if (consume) begin
                deq_valid   <= 1'b0;
                enq_out_sop <= 1'b0;
                enq_out_eop <= 1'b0;
            end
        end
    end

endmodule
